// File: rtl/display_scan_mux_if.sv
// Host-side load bus and decoder/anode drive for display_scan_mux.
// The host (master) supplies the value to show; the scanner (slave) drives the digit.
interface display_scan_mux_if #(
   parameter int DIGITS = 4
);
   localparam int IDX_W = $clog2(DIGITS);

   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_mask;
   logic                  lz_en;
   logic [3:0]            dado;
   logic                  dp;
   logic [DIGITS-1:0]     an;
   logic [IDX_W-1:0]      digit_idx;
   logic                  frame_tick;

   modport master (
      output load, value, dp_mask, lz_en,
      input  dado, dp, an, digit_idx, frame_tick
   );

   modport slave (
      input  load, value, dp_mask, lz_en,
      output dado, dp, an, digit_idx, frame_tick
   );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner with a double-buffered value, inter-digit
// blanking and leading-zero suppression. An update takes effect at a frame boundary.
module display_scan_mux #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   display_scan_mux_if.slave   bus
);
   localparam int IDX_W = $clog2(DIGITS);
   localparam int CNT_W = $clog2(REFRESH_DIV);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [DIGITS-1:0][3:0]     act_q, act_d, pend_q, pend_d;
   logic [DIGITS-1:0]          act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic [3:0]                 dado_q, dado_d;
   logic                       dp_q, dp_d;
   logic                       tick_q, tick_d;

   logic                       slot_end, frame_end;
   logic                       clear_run;
   logic [DIGITS-1:0]          supp;
   logic [DIGITS-1:0]          an_c;

   always_comb begin
      slot_end  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
      frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));

      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;

      pend_d    = pend_q;
      pend_dp_d = pend_dp_q;
      if (bus.load) begin
         pend_d    = bus.value;
         pend_dp_d = bus.dp_mask;
      end

      // A load on the wrap cycle is copied to active at the same edge.
      act_d    = act_q;
      act_dp_d = act_dp_q;
      if (frame_end) begin
         act_d    = pend_d;
         act_dp_d = pend_dp_d;
      end

      // The nibble and dp are latched at slot start, ahead of the anode enable.
      dado_d = dado_q;
      dp_d   = dp_q;
      if (slot_end) begin
         dado_d = act_d[idx_d];
         dp_d   = act_dp_d[idx_d];
      end

      tick_d = frame_end;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BLANK: if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = SHOW;
         SHOW:  if (slot_end) state_d = BLANK;
         default: state_d = BLANK;
      endcase
   end

   // Digit i is suppressed when it and every digit above it are zero with no dp.
   always_comb begin
      clear_run = 1'b1;
      supp      = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         clear_run = clear_run & (act_q[i] == 4'h0) & ~act_dp_q[i];
         if (i > 0) supp[i] = bus.lz_en & clear_run;
      end
   end

   always_comb begin
      an_c = '1;
      if (state_q == SHOW && !supp[idx_q]) an_c[idx_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BLANK;
         cnt_q     <= '0;
         idx_q     <= '0;
         act_q     <= '0;
         act_dp_q  <= '0;
         pend_q    <= '0;
         pend_dp_q <= '0;
         dado_q    <= '0;
         dp_q      <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         act_q     <= act_d;
         act_dp_q  <= act_dp_d;
         pend_q    <= pend_d;
         pend_dp_q <= pend_dp_d;
         dado_q    <= dado_d;
         dp_q      <= dp_d;
         tick_q    <= tick_d;
      end
   end

   assign bus.an         = an_c;
   assign bus.dado       = dado_q;
   assign bus.dp         = dp_q;
   assign bus.digit_idx  = idx_q;
   assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux (4 digits, 8-cycle slots, 2-cycle blanking).
// Table of loads with per-slot expectations queued and checked frame by frame.
module tb_display_scan_mux;
   localparam int DIGITS = 4;
   localparam int RD     = 8;
   localparam int BL     = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   display_scan_mux_if #(.DIGITS(DIGITS)) bus();

   display_scan_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dpm;
      logic        lz;
      logic [15:0] dado;   // nibble s = expected dado in slot s
      logic [3:0]  dp;     // bit s = expected dp in slot s
      logic [15:0] an;     // nibble s = expected an while lit in slot s
   } vec_t;

   typedef struct {
      logic [1:0] idx;
      logic [3:0] dado;
      logic       dp;
      logic [3:0] an;
   } slot_t;

   vec_t  tbl [7];
   slot_t exp_q [$];
   int    n_vec = 0;
   int    n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [15:0] dado, input logic [3:0] dp, input logic [15:0] an);
      slot_t e;
      for (int s = 0; s < DIGITS; s++) begin
         e.idx  = 2'(s);
         e.dado = dado[4*s +: 4];
         e.dp   = dp[s];
         e.an   = an[4*s +: 4];
         exp_q.push_back(e);
      end
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] dpm, input logic lz);
      bus.value   = v;
      bus.dp_mask = dpm;
      bus.lz_en   = lz;
      bus.load    = 1'b1;
      @(negedge clk);
      bus.load    = 1'b0;
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!bus.frame_tick && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.frame_tick) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_tick: frame_tick absent after %0d cycles", n);
      end
   endtask

   task automatic wait_idx(input logic [1:0] idx);
      int n = 0;
      while (bus.digit_idx !== idx && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wait_idx", 32'(bus.digit_idx), 32'(idx));
   endtask

   // Called at the negedge of a frame_tick cycle; checks all 32 cycles of the frame.
   task automatic check_frame(input string name);
      slot_t e;
      logic [3:0] ea;
      logic ok;
      for (int s = 0; s < DIGITS; s++) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty at slot %0d", name, s);
            return;
         end
         e  = exp_q.pop_front();
         ok = 1'b1;
         for (int c = 0; c < RD; c++) begin
            ea = (c < BL) ? 4'hF : e.an;
            if (ok && (bus.an !== ea || bus.dado !== e.dado || bus.dp !== e.dp ||
                       bus.digit_idx !== e.idx || bus.frame_tick !== (s == 0 && c == 0))) begin
               ok = 1'b0;
               n_bad++;
               $display("FAIL %s slot %0d cyc %0d: got an=%b dado=%h dp=%b idx=%0d tick=%b expected an=%b dado=%h dp=%b idx=%0d tick=%b",
                        name, s, c, bus.an, bus.dado, bus.dp, bus.digit_idx, bus.frame_tick,
                        ea, e.dado, e.dp, e.idx, (s == 0 && c == 0));
            end
            @(negedge clk);
         end
         n_vec++;
      end
   endtask

   initial begin
      tbl[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b0000, 16'h7BDE};
      tbl[1] = '{16'h0050, 4'b0000, 1'b1, 16'h0050, 4'b0000, 16'hFFDE};
      tbl[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 16'hFFFE};
      tbl[3] = '{16'h0007, 4'b0100, 1'b1, 16'h0007, 4'b0100, 16'hFBDE};
      tbl[4] = '{16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 16'h7BDE};
      tbl[5] = '{16'h8001, 4'b1000, 1'b1, 16'h8001, 4'b1000, 16'h7BDE};
      tbl[6] = '{16'h00F0, 4'b0001, 1'b1, 16'h00F0, 4'b0001, 16'hFFDE};

      rst         = 1'b1;
      bus.load    = 1'b0;
      bus.value   = '0;
      bus.dp_mask = '0;
      bus.lz_en   = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_an",   32'(bus.an),         32'hF);
      check("rst_dado", 32'(bus.dado),       32'h0);
      check("rst_dp",   32'(bus.dp),         32'h0);
      check("rst_idx",  32'(bus.digit_idx),  32'h0);
      check("rst_tick", 32'(bus.frame_tick), 32'h0);
      rst = 1'b0;
      for (int c = 0; c < RD; c++) begin
         check("post_rst_an", 32'(bus.an), (c < BL) ? 32'hF : 32'hE);
         if (c == 0) check("post_rst_tick", 32'(bus.frame_tick), 32'h0);
         @(negedge clk);
      end

      for (int i = 0; i < 7; i++) begin
         load_val(tbl[i].value, tbl[i].dpm, tbl[i].lz);
         push_frame(tbl[i].dado, tbl[i].dp, tbl[i].an);
         wait_tick();
         check_frame($sformatf("vec%0d", i));
      end

      // Load mid-frame: digits 2 and 3 keep the old value until the next frame.
      load_val(16'h1234, 4'b0000, 1'b0);
      push_frame(16'h1234, 4'b0000, 16'h7BDE);
      wait_tick();
      check_frame("tear_base");
      wait_idx(2'd2);
      load_val(16'hABCD, 4'b0000, 1'b0);
      check("tear_old_d2", 32'(bus.dado), 32'h2);
      wait_idx(2'd3);
      check("tear_old_d3", 32'(bus.dado), 32'h1);
      push_frame(16'hABCD, 4'b0000, 16'h7BDE);
      wait_tick();
      check_frame("tear_new");

      // Two loads in one frame: the second one is shown.
      load_val(16'h1111, 4'b0000, 1'b0);
      repeat (4) @(negedge clk);
      load_val(16'h2222, 4'b0011, 1'b0);
      push_frame(16'h2222, 4'b0011, 16'h7BDE);
      wait_tick();
      check_frame("last_wins");

      // Load on the wrap cycle (slot 3, cnt 7) goes straight to the display.
      repeat (RD*DIGITS - 1) @(negedge clk);
      load_val(16'h5678, 4'b0000, 1'b0);
      push_frame(16'h5678, 4'b0000, 16'h7BDE);
      check_frame("wrap_load");

      // Reset at slot 1 cnt 5 with a pending load outstanding.
      load_val(16'h9999, 4'b1111, 1'b0);
      repeat (RD + 5 - 1) @(negedge clk);
      check("pre_rst_idx", 32'(bus.digit_idx), 32'h1);
      check("pre_rst_an",  32'(bus.an),        32'hD);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_an",   32'(bus.an),         32'hF);
      check("mid_rst_dado", 32'(bus.dado),       32'h0);
      check("mid_rst_dp",   32'(bus.dp),         32'h0);
      check("mid_rst_idx",  32'(bus.digit_idx),  32'h0);
      check("mid_rst_tick", 32'(bus.frame_tick), 32'h0);
      push_frame(16'h0000, 4'b0000, 16'h7BDE);
      wait_tick();
      check_frame("mid_rst_empty");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
